top_k_streamer: RTL and testbench

TOP_K_STREAMER -- requirements
Module: top_k_streamer

---
 rtl/top_k_streamer.sv | 109 ++++++++++
 tb/tb_top_k_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_k_streamer.sv
// top_k_streamer: keeps the DEPTH largest unsigned samples seen since the last
// burst in a descending-sorted register list, then streams them out largest
// first on flush.
// Optional feature macro: TOP_K_STREAMER_DROP_CNT_EN adds a 16-bit saturating
// drop_cnt output counting din_valid beats ignored while emitting.
module top_k_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         din_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_last,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef TOP_K_STREAMER_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mem    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_nx [DEPTH];
  logic [CW-1:0]         count_nx;
  logic [CW-1:0]         pos;
  logic                  full;
  logic                  insert;
  logic                  pop;

  // Insertion point, list update, count and state transitions.
  always_comb begin
    state_nx = state;
    count_nx = count;
    mem_nx   = mem;

    // pos = number of retained entries >= din, so equal values land after existing ones
    pos = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (mem[i] >= din)) pos = pos + CW'(1);
    end

    full   = (count == CW'(DEPTH));
    insert = (state == COLLECT) && din_valid && !(full && (pos == CW'(DEPTH)));
    pop    = (state == EMIT) && dout_ready;

    if (insert) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (CW'(i) > pos) mem_nx[i] = mem[i-1];
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == pos) mem_nx[i] = din;
      end
      if (!full) count_nx = count + CW'(1);
    end

    // a sample arriving with flush on an empty list still forms a one-entry burst
    if ((state == COLLECT) && flush && ((count != '0) || din_valid)) state_nx = EMIT;

    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) mem_nx[i] = mem[i+1];
      mem_nx[DEPTH-1] = '0;
      count_nx        = count - CW'(1);
      if (count == CW'(1)) state_nx = COLLECT;
    end
  end

  // State, count and sorted list registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= COLLECT;
      count <= '0;
      mem   <= '{default: '0};
    end else begin
      state <= state_nx;
      count <= count_nx;
      mem   <= mem_nx;
    end
  end

  // Output decode from the registered state and list head.
  always_comb begin
    in_ready   = (state == COLLECT);
    dout_valid = (state == EMIT);
    dout       = dout_valid ? mem[0] : '0;
    dout_last  = dout_valid && (count == CW'(1));
  end

`ifdef TOP_K_STREAMER_DROP_CNT_EN
  // Saturating count of samples offered while emitting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if ((state == EMIT) && din_valid && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_top_k_streamer.sv
// Directed self-checking bench for top_k_streamer (DEPTH=4, DATA_WIDTH=32).
module tb_top_k_streamer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] din;
  logic        din_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic [2:0]  count;
`ifdef TOP_K_STREAMER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  top_k_streamer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .count      (count)
`ifdef TOP_K_STREAMER_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Offer one sample on the next rising edge; returns on the following falling edge.
  task automatic push(input logic [31:0] v);
    din       = v;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; din = 32'd11; din_valid = 1'b1; flush = 1'b0; dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid got %b exp 0", dout_valid); end
    checks++; if (dout !== 32'd0) begin errors++; $display("FAIL rst_dout got %0d exp 0", dout); end
    checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL rst_dout_last got %b exp 0", dout_last); end
    resetn = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rst_first_accept count got %0d exp 1", count); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd11 || dout_last !== 1'b1) begin
      errors++; $display("FAIL rst_first_emit got v=%b d=%0d l=%b exp v=1 d=11 l=1", dout_valid, dout, dout_last);
    end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL rst_first_done got v=%b c=%0d exp v=0 c=0", dout_valid, count);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_q [4] = '{32'd9, 32'd7, 32'd5, 32'd3};
    dout_ready = 1'b1;
    push(5); push(9); push(1); push(7); push(3);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL basic_count_sat got %0d exp 4", count); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_valid !== 1'b1 || dout !== exp_q[i]) begin
        errors++; $display("FAIL basic_dout[%0d] got v=%b d=%0d exp v=1 d=%0d", i, dout_valid, dout, exp_q[i]);
      end
      checks++; if (dout_last !== (i == 3)) begin
        errors++; $display("FAIL basic_last[%0d] got %b exp %b", i, dout_last, (i == 3));
      end
      checks++; if (count !== 3'(4 - i) || in_ready !== 1'b0) begin
        errors++; $display("FAIL basic_count[%0d] got c=%0d r=%b exp c=%0d r=0", i, count, in_ready, 4 - i);
      end
      @(negedge clk);
    end
    checks++; if (dout_valid !== 1'b0 || dout !== 32'd0 || count !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_end got v=%b d=%0d c=%0d r=%b exp v=0 d=0 c=0 r=1", dout_valid, dout, count, in_ready);
    end
  endtask

  task automatic test_duplicates();
    logic [31:0] exp_q [3] = '{32'd6, 32'd6, 32'd2};
    dout_ready = 1'b1;
    push(6); push(6); push(2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout_valid !== 1'b1 || dout !== exp_q[i] || dout_last !== (i == 2)) begin
        errors++; $display("FAIL dup_dout[%0d] got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                           i, dout_valid, dout, dout_last, exp_q[i], (i == 2));
      end
      @(negedge clk);
    end
    checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL dup_end got v=%b c=%0d exp v=0 c=0", dout_valid, count);
    end
  endtask

  task automatic test_full_displace();
    logic [31:0] exp_q [4] = '{32'd8, 32'd6, 32'd5, 32'd4};
    dout_ready = 1'b1;
    push(4); push(6); push(8); push(2);
    push(2); push(1);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    push(5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_valid !== 1'b1 || dout !== exp_q[i] || dout_last !== (i == 3)) begin
        errors++; $display("FAIL full_dout[%0d] got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                           i, dout_valid, dout, dout_last, exp_q[i], (i == 3));
      end
      @(negedge clk);
    end
    checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL full_end got v=%b c=%0d exp v=0 c=0", dout_valid, count);
    end
  endtask

  task automatic test_flush_same_cycle();
    dout_ready = 1'b1;
    din = 32'd4; din_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; flush = 1'b0; din = '0;
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd4 || dout_last !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL same_cycle got v=%b d=%0d l=%b c=%0d exp v=1 d=4 l=1 c=1",
                         dout_valid, dout, dout_last, count);
    end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL same_cycle_end got v=%b c=%0d exp v=0 c=0", dout_valid, count);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL empty_flush[%0d] got v=%b r=%b exp v=0 r=1", i, dout_valid, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    dout_ready = 1'b0;
    push(8); push(3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_valid !== 1'b1 || dout !== 32'd8 || count !== 3'd2 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got v=%b d=%0d c=%0d r=%b exp v=1 d=8 c=2 r=0",
                           i, dout_valid, dout, count, in_ready);
      end
      // samples and flush offered while emitting must be ignored
      din = 32'd100; din_valid = (i < 3); flush = (i < 3);
      if (i == 3) dout_ready = 1'b1;
      @(negedge clk);
    end
    din = '0;
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd3 || dout_last !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL release got v=%b d=%0d l=%b c=%0d exp v=1 d=3 l=1 c=1",
                         dout_valid, dout, dout_last, count);
    end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL release_end got v=%b c=%0d exp v=0 c=0", dout_valid, count);
    end
  endtask

  task automatic test_reset_mid_burst();
    dout_ready = 1'b1;
    push(9); push(7); push(5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd9) begin
      errors++; $display("FAIL mid_first got v=%b d=%0d exp v=1 d=9", dout_valid, dout);
    end
    resetn = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0 || dout !== 32'd0 || dout_last !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b d=%0d l=%b c=%0d r=%b exp v=0 d=0 l=0 c=0 r=1",
                         dout_valid, dout, dout_last, count, in_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
        errors++; $display("FAIL mid_idle[%0d] got v=%b c=%0d exp v=0 c=0", i, dout_valid, count);
      end
    end
    din = 32'd2; din_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; flush = 1'b0; din = '0;
    checks++; if (dout_valid !== 1'b1 || dout !== 32'd2 || dout_last !== 1'b1) begin
      errors++; $display("FAIL mid_new got v=%b d=%0d l=%b exp v=1 d=2 l=1", dout_valid, dout, dout_last);
    end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL mid_new_end got v=%b c=%0d exp v=0 c=0", dout_valid, count);
    end
  endtask

  task automatic test_drop_cnt();
`ifdef TOP_K_STREAMER_DROP_CNT_EN
    logic [15:0] base;
    base = drop_cnt;
    dout_ready = 1'b0;
    push(1); push(2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    din = 32'd77; din_valid = 1'b1;
    repeat (3) @(negedge clk);
    din_valid = 1'b0; din = '0;
    checks++; if (drop_cnt !== 16'(base + 16'd3)) begin
      errors++; $display("FAIL drop_cnt got %0d exp %0d", drop_cnt, base + 16'd3);
    end
    checks++; if (dout !== 32'd2 || count !== 3'd2) begin
      errors++; $display("FAIL drop_burst got d=%0d c=%0d exp d=2 c=2", dout, count);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    checks++; if (dout !== 32'd1 || dout_last !== 1'b1) begin
      errors++; $display("FAIL drop_tail got d=%0d l=%b exp d=1 l=1", dout, dout_last);
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duplicates();
    test_full_displace();
    test_flush_same_cycle();
    test_backpressure();
    test_reset_mid_burst();
    test_drop_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
